// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces x/y counts, hsync/vsync with selectable polarity and a display enable.
// It also produces line/frame start strobes and a frame counter. Counting
// advances only on clocks where the pixel enable ce is high. An output
// pipeline of DELAY stages keeps every output aligned to the same pixel slot.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN builds the frame counter;
// without it frame_count is tied to zero.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CW        = 10,
    parameter int   DELAY     = 2,
    parameter int   FW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_count
);

    localparam int     H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int     V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam longint CNT_LIM = longint'(1) << CW;

    // Range limits are expressed as inclusive last values so that every
    // constant fits in CW bits even when a following porch is zero.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_LAST = CW'(H_VISIBLE - 1);
    localparam logic [CW-1:0] V_VIS_LAST = CW'(V_VISIBLE - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Reject configurations whose counts cannot be represented in CW bits.
    generate
        if (longint'(H_TOTAL) > CNT_LIM || longint'(V_TOTAL) > CNT_LIM) begin : g_cw_check
            $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
        end
        if (H_VISIBLE < 1 || V_VISIBLE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_zero_check
            $error("vga_timing_gen: visible and sync widths must be at least 1");
        end
        if (DELAY < 0 || DELAY > 4) begin : g_delay_check
            $error("vga_timing_gen: DELAY must be in 0..4");
        end
    endgenerate

    // One pixel slot worth of decoded timing information.
    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          hs;
        logic          vs;
        logic          de;
        logic          ls;
        logic          fs;
    } tap_t;

    localparam tap_t TAP_RST = {{CW{1'b0}}, {CW{1'b0}}, ~HS_POL, ~VS_POL, 3'b000};

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    tap_t          tap_d;
    tap_t          tap_out;

    // Horizontal and vertical raster counters, stepped once per pixel slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (ce) begin
            if (h == H_LAST) begin
                h <= '0;
                if (v == V_LAST) begin
                    v <= '0;
                end else begin
                    v <= v + CW'(1);
                end
            end else begin
                h <= h + CW'(1);
            end
        end
    end

    // Decode of the current counter position into sync, enable and strobe bits.
    always_comb begin
        tap_d.x  = h;
        tap_d.y  = v;
        tap_d.hs = ((h >= HS_FIRST) && (h <= HS_LAST)) ? HS_POL : ~HS_POL;
        tap_d.vs = ((v >= VS_FIRST) && (v <= VS_LAST)) ? VS_POL : ~VS_POL;
        tap_d.de = (h <= H_VIS_LAST) && (v <= V_VIS_LAST);
        tap_d.ls = (h == '0);
        tap_d.fs = (h == '0) && (v == '0);
    end

    generate
        if (DELAY == 0) begin : g_nodly
            assign tap_out = tap_d;
        end else begin : g_dly
            tap_t tap_p [DELAY];

            // Output delay line; every stage advances only in a pixel slot.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DELAY; i++) begin
                        tap_p[i] <= TAP_RST;
                    end
                end else if (ce) begin
                    tap_p[0] <= tap_d;
                    for (int i = 1; i < DELAY; i++) begin
                        tap_p[i] <= tap_p[i-1];
                    end
                end
            end

            assign tap_out = tap_p[DELAY-1];
        end
    endgenerate

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FW-1:0] fc;

    // Completed-frame counter, bumped on the slot that ends the last line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc <= '0;
        end else if (ce && (h == H_LAST) && (v == V_LAST)) begin
            fc <= fc + FW'(1);
        end
    end

    generate
        if (DELAY == 0) begin : g_fc_nodly
            assign frame_count = fc;
        end else begin : g_fc_dly
            logic [FW-1:0] fc_p [DELAY];

            // Frame count travels through the same number of stages as the taps.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DELAY; i++) begin
                        fc_p[i] <= '0;
                    end
                end else if (ce) begin
                    fc_p[0] <= fc;
                    for (int i = 1; i < DELAY; i++) begin
                        fc_p[i] <= fc_p[i-1];
                    end
                end
            end

            assign frame_count = fc_p[DELAY-1];
        end
    endgenerate
`else
    assign frame_count = '0;
`endif

    assign x          = tap_out.x;
    assign y          = tap_out.y;
    assign hsync      = tap_out.hs;
    assign vsync      = tap_out.vs;
    assign display_on = tap_out.de;
    // Gating with ce keeps each strobe one clk wide even when slots span many clks.
    assign line_start  = tap_out.ls & ce;
    assign frame_start = tap_out.fs & ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance with no delay,
// plus two small-raster instances (15x8 totals) with DELAY=0 / active-low syncs
// and DELAY=2 / active-high syncs, all sharing clk, reset and ce.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Default timing, DELAY=0.
    logic [9:0] def_x, def_y;
    logic       def_hs, def_vs, def_de, def_ls, def_fs;
    logic [7:0] def_fc;

    // Small raster: H 8/2/3/2 (total 15, sync 10..12), V 4/1/2/1 (total 8, sync 5..6).
    logic [4:0] sa_x, sa_y, sb_x, sb_y;
    logic       sa_hs, sa_vs, sa_de, sa_ls, sa_fs;
    logic       sb_hs, sb_vs, sb_de, sb_ls, sb_fs;
    logic [1:0] sa_fc, sb_fc;

    vga_timing_gen #(.DELAY(0)) u_def (
        .clk(clk), .reset(reset), .ce(ce),
        .x(def_x), .y(def_y), .hsync(def_hs), .vsync(def_vs),
        .display_on(def_de), .line_start(def_ls), .frame_start(def_fs),
        .frame_count(def_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(5), .DELAY(0), .FW(2)
    ) u_sa (
        .clk(clk), .reset(reset), .ce(ce),
        .x(sa_x), .y(sa_y), .hsync(sa_hs), .vsync(sa_vs),
        .display_on(sa_de), .line_start(sa_ls), .frame_start(sa_fs),
        .frame_count(sa_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(5), .DELAY(2), .FW(2)
    ) u_sb (
        .clk(clk), .reset(reset), .ce(ce),
        .x(sb_x), .y(sb_y), .hsync(sb_hs), .vsync(sb_vs),
        .display_on(sb_de), .line_start(sb_ls), .frame_start(sb_fs),
        .frame_count(sb_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the state reached after p pixel slots since reset.
    task automatic check_state(input int p);
        int dx, dy, sx, sy, m, bx, by;
        logic c;
        c  = ce;
        dx = p % 800;
        dy = (p / 800) % 525;
        chk("def_x",  def_x,  dx);
        chk("def_y",  def_y,  dy);
        chk("def_hs", def_hs, !(dx >= 656 && dx <= 751));
        chk("def_vs", def_vs, !(dy >= 490 && dy <= 491));
        chk("def_de", def_de, (dx < 640) && (dy < 480));
        chk("def_ls", def_ls, (dx == 0) && c);

        sx = p % 15;
        sy = (p / 15) % 8;
        chk("sa_x",  sa_x,  sx);
        chk("sa_y",  sa_y,  sy);
        chk("sa_hs", sa_hs, !(sx >= 10 && sx <= 12));
        chk("sa_vs", sa_vs, !(sy >= 5 && sy <= 6));
        chk("sa_de", sa_de, (sx < 8) && (sy < 4));
        chk("sa_ls", sa_ls, (sx == 0) && c);
        chk("sa_fs", sa_fs, (sx == 0) && (sy == 0) && c);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("sa_fc", sa_fc, (p / 120) % 4);
`else
        chk("sa_fc", sa_fc, 0);
`endif

        if (p < 2) begin
            chk("sb_x",  sb_x,  0);
            chk("sb_y",  sb_y,  0);
            chk("sb_hs", sb_hs, 0);
            chk("sb_vs", sb_vs, 0);
            chk("sb_de", sb_de, 0);
            chk("sb_ls", sb_ls, 0);
            chk("sb_fs", sb_fs, 0);
            chk("sb_fc", sb_fc, 0);
        end else begin
            m  = p - 2;
            bx = m % 15;
            by = (m / 15) % 8;
            chk("sb_x",  sb_x,  bx);
            chk("sb_y",  sb_y,  by);
            chk("sb_hs", sb_hs, (bx >= 10 && bx <= 12));
            chk("sb_vs", sb_vs, (by >= 5 && by <= 6));
            chk("sb_de", sb_de, (bx < 8) && (by < 4));
            chk("sb_ls", sb_ls, (bx == 0) && c);
            chk("sb_fs", sb_fs, (bx == 0) && (by == 0) && c);
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("sb_fc", sb_fc, (m / 120) % 4);
`else
            chk("sb_fc", sb_fc, 0);
`endif
        end
    endtask

    initial begin
        int p;
        int last_ls;
        int fs_seen;

        // Reset held with ce low: reset values, DELAY=0 enable already high.
        reset = 1'b1;
        ce    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state(0);
        chk("def_fs_rst", def_fs, 0);

        // With DELAY=0 the strobes follow ce straight away; delayed ones stay low.
        ce = 1'b1;
        #1;
        check_state(0);
        chk("def_fs_ce", def_fs, 1);

        // Continuous pixel enable from reset release.
        reset = 1'b0;
        fs_seen = 0;
        for (int n = 1; n <= 1900; n++) begin
            @(posedge clk);
            #1;
            check_state(n);
            if (sa_fs) fs_seen++;
        end
        // 1900 slots cover frame starts at 120,240,...,1800 on the small raster.
        chk("sa_fs_count", fs_seen, 15);
        chk("def_x_mid", def_x, 300);

        // Asynchronous reset mid-line, no clock edge in between.
        #1;
        reset = 1'b1;
        #1;
        check_state(0);

        // Release with a one-in-four pixel enable.
        ce = 1'b0;
        #1;
        reset = 1'b0;
        p = 0;
        last_ls = -1;
        for (int c = 0; c < 3300; c++) begin
            ce = (c % 4 == 0);
            #1;
            check_state(p);
            if (def_ls) begin
                if (last_ls >= 0) chk("def_line_period", c - last_ls, 3200);
                last_ls = c;
            end
            @(posedge clk);
            if (ce) p++;
            #1;
        end
        chk("def_line_seen", last_ls, 3200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator that supersedes the fixed-polarity, full-rate VGA sync counter. It adds a pixel clock-enable so the block can run from a fast system clock, and selectable sync polarity for non-VGA modes. A configurable output pipeline keeps all outputs aligned with a downstream pixel pipeline, and the block emits line-start and frame-start strobes plus a frame counter. It sits between the clock/reset logic and the game renderer/colour mux, and drives the monitor sync pins.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- VS_POL, 0, vsync active level
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- DELAY, 2, output pipeline depth in pixel slots (0..4)
- FW, 8, frame counter width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ce  in  1  pixel enable; one pixel slot per clk with ce=1
- x  out  CW  horizontal count, including blanking (0..H_TOTAL-1)
- y  out  CW  vertical count, including blanking (0..V_TOTAL-1)
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- display_on  out  1  high when x < H_VISIBLE and y < V_VISIBLE
- line_start  out  1  one-clk strobe when x == 0
- frame_start  out  1  one-clk strobe when x == 0 and y == 0
- frame_count  out  FW  completed-frame count, wraps modulo 2^FW

## Operation
- H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK. V_TOTAL is defined the same way from the V_ parameters.
- h/v counters advance only on clk edges with ce=1. With ce=0, counters, pipeline and outputs all hold.
- Counter stepping:
  - h wraps from H_TOTAL-1 to 0.
  - On that wrap, v increments.
  - v wraps from V_TOTAL-1 to 0 on the same edge as the h wrap.
- Frame counter:
  - Increments (modulo 2^FW) on the ce edge where h = H_TOTAL-1 and v = V_TOTAL-1.
  - Its value is sampled into the pipeline with the other decode bits.
- Decode stage, computed from the counter registers:
  - hs_act = H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC.
  - vs_act is the same range test using the V_ parameters and v.
  - de = h < H_VISIBLE and v < V_VISIBLE.
  - ls = (h == 0). fs = (h == 0 and v == 0).
- Output levels: hsync = hs_act ? HS_POL : ~HS_POL. vsync = vs_act ? VS_POL : ~VS_POL.
- Pipeline:
  - The bundle {x, y, hsync, vsync, de, ls, fs, frame_count} passes through DELAY register stages.
  - Each stage loads only on ce=1.
  - DELAY=0 makes the outputs combinational from the counter registers.
- Strobes:
  - line_start = ls_out AND ce. frame_start = fs_out AND ce.
  - Each strobe is exactly one clk wide, whatever the ce duty cycle.
- Arithmetic: all comparisons are unsigned at CW bits. Parameters that overflow CW are illegal, and the implementation must flag them in an elaboration-time check.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-line):
  - h = 0, v = 0, frame counter = 0.
  - Every pipeline stage resets to x=0, y=0, hsync=~HS_POL, vsync=~VS_POL, de=0, ls=0, fs=0, frame_count=0.
- Output values directly after reset:
  - With DELAY>0: display_on=0 and the strobes are 0 until the first DELAY ce pulses have flushed the pipeline.
  - With DELAY=0: display_on=1, and line_start/frame_start follow ce immediately.
- Latency: every output lags the counters by exactly DELAY ce slots. All outputs stay mutually aligned, so x shows value N in the same slot where hsync/de reflect N.
- Deasserting reset: counting starts at the first clk edge with ce=1 after reset falls.
- Steady state with ce=1 continuously:
  - Line period = H_TOTAL clk.
  - Frame period = H_TOTAL × V_TOTAL clk (420000 at the defaults).

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: the frame counter register and its pipeline bits are built, and frame_count behaves as specified above.
- VGA_TIMING_FRAME_CNT_EN not defined:
  - No frame counter logic is built, and frame_count is tied to 0.
  - All other behaviour is identical.

## Test plan
- Defaults, ce=1, DELAY=0:
  - hsync is low exactly while x = 656..751, with a period of 800 clk.
  - vsync is low exactly for lines y = 490..491.
  - frame_start recurs every 420000 clk.
- ce high one clk in four: line period = 3200 clk, and line_start and frame_start are each exactly 1 clk wide.
- DELAY=2:
  - The hsync falling edge coincides with x = 656 at the outputs.
  - display_on falls with x = 640.
  - Both occur 2 ce slots after the internal counter reaches that value.
- HS_POL=1, VS_POL=1: the sync outputs are the exact inversion of the defaults, and idle low from reset.
- Macro defined, FW=2: frame_count steps 0→1→2→3→0 across five frame_start strobes. With the macro undefined, frame_count stays 0 throughout.
- Reset asserted at x=300, y=100, with no clk edge:
  - All outputs take their reset values immediately.
  - After release, x increments from 0 on the first ce.
